// File: rtl/output_port_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : output_port_fifo
//  Brief    : Memory-mapped output register with a sticky last-value copy and
//             a DEPTH-entry valid/ready FIFO so a slow consumer can drain
//             every written value. Dropped writes raise a sticky overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module output_port_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             write_en,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  input  logic             clear_overflow
);

  // Pointer width; DEPTH is a power of two so pointers wrap naturally.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [PW-1:0] C_PINC  = PW'(1);

  // Storage and state registers
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             overflow_q, overflow_d;

  // Handshake decode
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Status flags come straight from the occupancy register.
  always_comb begin
    w_full  = (count_q == C_DEPTH);
    w_empty = (count_q == '0);
    w_pop   = !w_empty && out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    w_push  = write_en && (!w_full || w_pop);
    w_drop  = write_en && w_full && !w_pop;
  end

  // Next-state computation for pointers, occupancy, last value and overflow.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    overflow_d = overflow_q;

    if (w_push) begin
      wr_ptr_d = wr_ptr_q + C_PINC;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + C_PINC;
    end

    if (w_push && !w_pop) begin
      count_d = count_q + C_ONE;
    end else if (w_pop && !w_push) begin
      count_d = count_q - C_ONE;
    end

    // The sticky register follows every strobe, even a dropped one.
    if (write_en) begin
      data_out_d = data_in;
    end

    // Setting on a drop takes priority over a simultaneous clear.
    if (w_drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      overflow_q <= overflow_d;
    end
  end

  // Array write; contents are don't-care after reset so no reset term.
  always_ff @(posedge clock) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // Outputs are driven only from registers or the array at a registered index.
  always_comb begin
    data_out  = data_out_q;
    out_data  = mem_q[rd_ptr_q];
    out_valid = !w_empty;
    full      = w_full;
    empty     = w_empty;
    count     = count_q;
    overflow  = overflow_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_output_port_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_output_port_fifo
//  Brief    : Directed scoreboard bench for output_port_fifo (WIDTH=16,
//             DEPTH=4). Accepted writes are queued as expected values; a
//             monitor compares out_data on every handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_output_port_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             write_en;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             clear_overflow;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] exp_q [$];

  output_port_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .data_in        (data_in),
    .write_en       (write_en),
    .data_out       (data_out),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Queue an accepted write and drive it for one cycle.
  task automatic wr(input logic [WIDTH-1:0] v, input bit accepted);
    data_in  = v;
    write_en = 1'b1;
    if (accepted) exp_q.push_back(v);
    tick();
    write_en = 1'b0;
  endtask

  // Monitor: on the falling edge, a visible handshake will complete at the next rising edge.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected: got 0x%0h expected no entry at %0t", out_data, $time);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          failures++;
          $display("FAIL pop_data: got 0x%0h expected 0x%0h at %0t", out_data, e, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b0;
    data_in        = '0;
    write_en       = 1'b0;
    out_ready      = 1'b0;
    clear_overflow = 1'b0;

    // Reset asserted before any clock edge takes effect immediately.
    #3 reset = 1'b1;
    #1;
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // Basic ordering with the consumer stalled.
    wr(16'h1111, 1'b1); check("ord_count1", 32'(count), 32'd1);
    wr(16'h2222, 1'b1); check("ord_count2", 32'(count), 32'd2);
    wr(16'h3333, 1'b1); check("ord_count3", 32'(count), 32'd3);
    check("ord_data_out", 32'(data_out), 32'h3333);
    tick();
    check("ord_hold_count", 32'(count), 32'd3);
    out_ready = 1'b1;
    repeat (3) tick();
    check("ord_empty", 32'(empty), 32'd1);
    out_ready = 1'b0;

    // Fill to full, then drop the fifth write.
    wr(16'h00A0, 1'b1);
    wr(16'h00A1, 1'b1);
    wr(16'h00A2, 1'b1);
    check("ovf_not_full3", 32'(full), 32'd0);
    wr(16'h00A3, 1'b1);
    check("ovf_full4", 32'(full), 32'd1);
    check("ovf_overflow_pre", 32'(overflow), 32'd0);
    wr(16'h00A4, 1'b0);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_overflow", 32'(overflow), 32'd1);
    check("ovf_data_out", 32'(data_out), 32'h00A4);
    out_ready = 1'b1;
    repeat (4) tick();
    check("ovf_drained", 32'(empty), 32'd1);
    out_ready = 1'b0;

    // Clear overflow alone.
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("clr_overflow", 32'(overflow), 32'd0);

    // Simultaneous push and pop while full.
    wr(16'd1, 1'b1);
    wr(16'd2, 1'b1);
    wr(16'd3, 1'b1);
    wr(16'd4, 1'b1);
    check("pp_full", 32'(full), 32'd1);
    out_ready = 1'b1;
    wr(16'd5, 1'b1);
    check("pp_count", 32'(count), 32'd4);
    check("pp_overflow", 32'(overflow), 32'd0);
    check("pp_data_out", 32'(data_out), 32'd5);
    repeat (4) tick();
    check("pp_drained", 32'(empty), 32'd1);

    // Pointer wrap with the consumer always ready.
    for (int k = 0; k < 10; k++) begin
      wr(16'(k), 1'b1);
      check("wrap_valid", 32'(out_valid), 32'd1);
      check("wrap_count", 32'(count), 32'd1);
    end
    tick();
    check("wrap_empty", 32'(empty), 32'd1);
    out_ready = 1'b0;

    // Overflow priority: set wins over a simultaneous clear.
    wr(16'h00B0, 1'b1);
    wr(16'h00B1, 1'b1);
    wr(16'h00B2, 1'b1);
    wr(16'h00B3, 1'b1);
    wr(16'h00B4, 1'b0);
    check("pri_overflow_set", 32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    tick();
    check("pri_clear_alone", 32'(overflow), 32'd0);
    wr(16'h00B5, 1'b0);
    clear_overflow = 1'b0;
    check("pri_set_wins", 32'(overflow), 32'd1);
    check("pri_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    repeat (4) tick();
    check("pri_drained", 32'(empty), 32'd1);
    out_ready = 1'b0;

    // Reset mid-stream discards queued entries.
    wr(16'h0C01, 1'b1);
    wr(16'h0C02, 1'b1);
    check("mid_count", 32'(count), 32'd2);
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_data_out", 32'(data_out), 32'h0);
    tick();
    reset = 1'b0;
    wr(16'h0D0D, 1'b1);
    check("post_rst_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_rst_empty", 32'(empty), 32'd1);

    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
